// File: rtl/cpu_pkg.sv
// Shared CPU register-file types: write-back queue entry and register-file geometry.
package cpu_pkg;
  localparam int REG_W      = 16;
  localparam int REG_ADDR_W = 3;
  localparam int NUM_REGS   = 8;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [REG_W-1:0]      data;
  } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Circular buffer taking up to two pushes (a is older than b) and one pop per cycle.
// The entry array is exposed so the top level can scan it for hazards.
module wb_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1),
  parameter int PW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_a,
  input  wb_entry_t        entry_a,
  input  logic             push_b,
  input  wb_entry_t        entry_b,
  input  logic             pop,
  output wb_entry_t        entries [DEPTH],
  output logic [PW-1:0]    head_ptr,
  output logic [CW-1:0]    count
);
  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] tail_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (pop) head_ptr <= head_ptr + PW'(1);
      // When both push, a takes the tail slot and b the one after it.
      if (push_a) begin
        mem[tail_ptr] <= entry_a;
        if (push_b) mem[tail_ptr + PW'(1)] <= entry_b;
      end else if (push_b) begin
        mem[tail_ptr] <= entry_b;
      end
      tail_ptr <= tail_ptr + PW'(push_a) + PW'(push_b);
      count    <= count + CW'(push_a) + CW'(push_b) - CW'(pop);
    end
  end

  assign entries = mem;
endmodule

// File: rtl/writeback_queue.sv
// Register-file write-back queue: ALU/load intake with r0 filter, one write per
// cycle from the head, and RAW hazard/forward scan for two decode read ports.
module writeback_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH       = 4,
  parameter bit R0_WRITABLE = 1'b0,
  parameter int CW          = $clog2(DEPTH+1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_reg,
  input  logic [REG_W-1:0]      alu_data,
  input  logic                  mem_valid,
  output logic                  mem_ready,
  input  logic [REG_ADDR_W-1:0] mem_reg,
  input  logic [REG_W-1:0]      mem_data,
  output logic                  write_en,
  output logic [REG_ADDR_W-1:0] wreg,
  output logic [REG_W-1:0]      writedata,
  input  logic [REG_ADDR_W-1:0] rega,
  input  logic [REG_ADDR_W-1:0] regb,
  output logic                  hazard_a,
  output logic                  hazard_b,
  output logic [REG_W-1:0]      fwd_a,
  output logic [REG_W-1:0]      fwd_b,
  output logic [CW-1:0]         count
);
  localparam int PW = $clog2(DEPTH);

  wb_entry_t     entries [DEPTH];
  wb_entry_t     head;
  logic [PW-1:0] head_ptr;
  logic          mem_push, alu_push;

  // Readiness looks only at registered occupancy, so it never combinationally
  // depends on valid or on the pop.
  assign mem_ready = (count <= CW'(DEPTH-1));
  assign alu_ready = (count <= CW'(DEPTH-2));

  assign mem_push = mem_valid && mem_ready && (R0_WRITABLE || mem_reg != '0);
  assign alu_push = alu_valid && alu_ready && (R0_WRITABLE || alu_reg != '0);

  wb_fifo #(.DEPTH(DEPTH), .CW(CW), .PW(PW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_a   (mem_push),
    .entry_a  ('{addr: mem_reg, data: mem_data}),
    .push_b   (alu_push),
    .entry_b  ('{addr: alu_reg, data: alu_data}),
    .pop      (write_en),
    .entries  (entries),
    .head_ptr (head_ptr),
    .count    (count)
  );

  assign head      = entries[head_ptr];
  assign write_en  = (count != '0);
  assign wreg      = write_en ? head.addr : '0;
  assign writedata = write_en ? head.data : '0;

  // Walk oldest to youngest so the last hit leaves the youngest data.
  function automatic logic [REG_W:0] scan(input logic [REG_ADDR_W-1:0] ra);
    logic [REG_W:0] res;
    logic [PW-1:0]  idx;
    res = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_ptr + PW'(i);
      if (CW'(i) < count && entries[idx].addr == ra)
        res = {1'b1, entries[idx].data};
    end
    if (!R0_WRITABLE && ra == '0) res = '0;
    return res;
  endfunction

  always_comb begin
    {hazard_a, fwd_a} = scan(rega);
    {hazard_b, fwd_b} = scan(regb);
  end
endmodule

// File: tb/tb_writeback_queue.sv
// Randomized and directed bench for writeback_queue against a queue-based model.
module tb_writeback_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, mem_valid, alu_ready, mem_ready;
  logic [2:0]  alu_reg, mem_reg, wreg, rega, regb;
  logic [15:0] alu_data, mem_data, writedata, fwd_a, fwd_b;
  logic        write_en, hazard_a, hazard_b;
  logic [2:0]  count;

  writeback_queue #(.DEPTH(DEPTH), .R0_WRITABLE(1'b0)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_reg(alu_reg), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_reg(mem_reg), .mem_data(mem_data),
    .write_en(write_en), .wreg(wreg), .writedata(writedata),
    .rega(rega), .regb(regb), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [2:0] r; logic [15:0] d; } ent_t;
  ent_t q[$];
  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Youngest queued write to ra; r0 never reports.
  task automatic ref_haz(input logic [2:0] ra, output bit hit, output logic [15:0] d);
    hit = 0; d = '0;
    if (ra != 0)
      for (int j = q.size() - 1; j >= 0; j--)
        if (q[j].r == ra) begin hit = 1; d = q[j].d; break; end
  endtask

  task automatic step(input bit mv, input logic [2:0] mr, input logic [15:0] md,
                      input bit av, input logic [2:0] ar, input logic [15:0] ad,
                      input logic [2:0] ra, input logic [2:0] rb, input bit r);
    int n; bit emr, ear, ha, hb; logic [15:0] fa, fb;
    @(negedge clk);
    mem_valid = mv; mem_reg = mr; mem_data = md;
    alu_valid = av; alu_reg = ar; alu_data = ad;
    rega = ra; regb = rb; rst = r;
    #1;
    n = q.size();
    emr = (n <= DEPTH - 1);
    ear = (n <= DEPTH - 2);
    chk("count", 32'(count), 32'(n));
    chk("mem_ready", 32'(mem_ready), 32'(emr));
    chk("alu_ready", 32'(alu_ready), 32'(ear));
    chk("write_en", 32'(write_en), 32'(n != 0));
    chk("wreg", 32'(wreg), n != 0 ? 32'(q[0].r) : 32'd0);
    chk("writedata", 32'(writedata), n != 0 ? 32'(q[0].d) : 32'd0);
    ref_haz(ra, ha, fa);
    ref_haz(rb, hb, fb);
    chk("hazard_a", 32'(hazard_a), 32'(ha));
    chk("fwd_a", 32'(fwd_a), 32'(fa));
    chk("hazard_b", 32'(hazard_b), 32'(hb));
    chk("fwd_b", 32'(fwd_b), 32'(fb));
    if (r) q.delete();
    else begin
      if (n != 0) void'(q.pop_front());
      if (mv && emr && mr != 0) q.push_back('{r: mr, d: md});
      if (av && ear && ar != 0) q.push_back('{r: ar, d: ad});
    end
  endtask

  task automatic idle(input logic [2:0] ra, input logic [2:0] rb);
    step(0, 0, 0, 0, 0, 0, ra, rb, 0);
  endtask

  initial begin
    rst = 1; alu_valid = 0; mem_valid = 0;
    alu_reg = 0; mem_reg = 0; alu_data = 0; mem_data = 0; rega = 0; regb = 0;
    repeat (2) @(posedge clk);
    // Reset state and single write
    step(0, 0, 0, 1, 3, 16'h00AA, 3, 0, 0);
    idle(3, 3);
    idle(3, 0);
    // Dual accept to the same register: mem older, alu younger
    step(1, 2, 16'h1111, 1, 2, 16'h2222, 2, 2, 0);
    idle(2, 5);
    idle(2, 5);
    idle(2, 5);
    // Backpressure: both sources held valid
    for (int i = 0; i < 6; i++)
      step(1, 3'(1 + i % 7), 16'h3000 + 16'(i), 1, 3'(4 + i % 3), 16'h4000 + 16'(i), 4, 1, 0);
    repeat (5) idle(1, 5);
    // r0 drop
    step(0, 0, 0, 1, 0, 16'hFFFF, 0, 0, 0);
    idle(0, 0);
    step(1, 0, 16'hEEEE, 1, 0, 16'hDDDD, 0, 0, 0);
    idle(0, 0);
    // Reset mid-burst
    step(1, 5, 16'h5555, 1, 6, 16'h6666, 5, 6, 0);
    step(1, 7, 16'h7777, 0, 0, 0, 7, 6, 0);
    step(0, 0, 0, 0, 0, 0, 7, 6, 1);
    idle(7, 6);
    idle(5, 6);
    // Wrap-around: 10 sequential accepts
    for (int i = 0; i < 10; i++)
      step(0, 0, 0, 1, 3'(1 + i % 7), 16'hA000 + 16'(i), 3'(1 + i % 7), 1, 0);
    repeat (2) idle(1, 2);
    // Random traffic
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 16'($urandom),
           $urandom_range(0, 9) < 6, 3'($urandom_range(0, 7)), 16'($urandom),
           3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom_range(0, 99) == 0);
    repeat (5) idle(0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
